// File: rtl/key_entry_de10.sv
// Four-key debounced BCD entry block for the DE10 pushbuttons.
// Edits a two-digit value and commits it as binary on out_reg.
module key_entry_de10 #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned TIMEOUT_CYCLES  = 250000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  key_n,
    output logic [31:0] out_reg,
    output logic        out_valid,
    output logic [3:0]  edit_ones,
    output logic [3:0]  edit_tens,
    output logic        digit_sel,
    output logic        editing
);

    localparam logic [19:0] DB_MAX = 20'(DEBOUNCE_CYCLES - 1);
    localparam logic [31:0] TO_MAX = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, EDIT, COMMIT} state_t;

    logic [3:0]  s1, s2, deb, armed, ev;
    logic [1:0]  prime;
    logic [19:0] dcnt [4];

    state_t      state, state_n;
    logic [3:0]  ones_n, tens_n;
    logic        sel_n, valid_n;
    logic [7:0]  out_val, out_n;
    logic [31:0] tcnt, tcnt_n;

    logic [3:0]  dig, dig_n, bt, bo;
    logic [7:0]  prod;
    logic        inc, dec;

    // Two-flop synchronizer; prime marks when s2 holds real key samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1    <= 4'hF;
            s2    <= 4'hF;
            prime <= 2'b00;
        end else begin
            s1    <= key_n;
            s2    <= s1;
            prime <= {prime[0], 1'b1};
        end
    end

    // Per-key debounce; a press only counts once the key was seen released
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb   <= 4'hF;
            armed <= 4'h0;
            ev    <= 4'h0;
            for (int k = 0; k < 4; k++) dcnt[k] <= '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                ev[k] <= 1'b0;
                if (prime[1] && s2[k] && deb[k])
                    armed[k] <= 1'b1;
                if (s2[k] == deb[k]) begin
                    dcnt[k] <= '0;
                end else if (dcnt[k] == DB_MAX) begin
                    deb[k]  <= s2[k];
                    dcnt[k] <= '0;
                    ev[k]   <= armed[k] & ~s2[k];
                end else begin
                    dcnt[k] <= dcnt[k] + 20'd1;
                end
            end
        end
    end

    assign inc  = ev[0] & ~ev[1];
    assign dec  = ev[1] & ~ev[0];
    assign dig  = digit_sel ? edit_tens : edit_ones;
    assign prod = {1'b0, edit_tens, 3'b000}
                + {3'b000, edit_tens, 1'b0}
                + {4'h0, edit_ones};

    // Wrapping digit step and BCD split of the committed value
    always_comb begin
        dig_n = dig;
        if (inc)
            dig_n = (dig == 4'd9) ? 4'd0 : dig + 4'd1;
        else if (dec)
            dig_n = (dig == 4'd0) ? 4'd9 : dig - 4'd1;
        bt = 4'd0;
        for (int i = 1; i <= 9; i++)
            if (out_val >= 8'(i * 10)) bt = 4'(i);
        bo = 4'(out_val - {1'b0, bt, 3'b000} - {3'b000, bt, 1'b0});
    end

    // Next-state and datapath updates for IDLE/EDIT/COMMIT
    always_comb begin
        state_n = state;
        ones_n  = edit_ones;
        tens_n  = edit_tens;
        sel_n   = digit_sel;
        out_n   = out_val;
        valid_n = 1'b0;
        tcnt_n  = tcnt;
        unique case (state)
            IDLE: begin
                tcnt_n = '0;
                if (|ev) state_n = EDIT;
            end
            EDIT: begin
                if (|ev) begin
                    tcnt_n = '0;
                    if (digit_sel) tens_n = dig_n;
                    else           ones_n = dig_n;
                    if (ev[2]) sel_n = ~digit_sel;
                    if (ev[3]) state_n = COMMIT;
                end else if (tcnt == TO_MAX) begin
                    tcnt_n  = '0;
                    ones_n  = bo;
                    tens_n  = bt;
                    sel_n   = 1'b0;
                    state_n = IDLE;
                end else begin
                    tcnt_n = tcnt + 32'd1;
                end
            end
            COMMIT: begin
                tcnt_n  = '0;
                out_n   = prod;
                valid_n = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // FSM and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            edit_ones <= 4'd0;
            edit_tens <= 4'd0;
            digit_sel <= 1'b0;
            out_val   <= 8'd0;
            out_valid <= 1'b0;
            tcnt      <= '0;
        end else begin
            state     <= state_n;
            edit_ones <= ones_n;
            edit_tens <= tens_n;
            digit_sel <= sel_n;
            out_val   <= out_n;
            out_valid <= valid_n;
            tcnt      <= tcnt_n;
        end
    end

    assign out_reg = {24'd0, out_val};
    assign editing = (state == EDIT);

endmodule

// File: tb/tb_key_entry_de10.sv
// Bench for key_entry_de10: vector table, random presses
// against a digit-level model, plus timeout and reset sequences.
module tb_key_entry_de10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  key_n = 4'hF;
    logic [31:0] out_reg;
    logic        out_valid;
    logic [3:0]  edit_ones, edit_tens;
    logic        digit_sel, editing;

    key_entry_de10 #(
        .DEBOUNCE_CYCLES(4),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .key_n(key_n),
        .out_reg(out_reg),
        .out_valid(out_valid),
        .edit_ones(edit_ones),
        .edit_tens(edit_tens),
        .digit_sel(digit_sel),
        .editing(editing)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int vcount = 0;

    always @(posedge clk) if (out_valid === 1'b1) vcount++;

    // model of the user-visible entry state
    int m_ones = 0, m_tens = 0, m_sel = 0, m_edit = 0, m_out = 0, m_v = 0;

    typedef struct {
        logic [3:0] keys;
        int ones;
        int tens;
        int sel;
        int edit;
        int outv;
        int vcnt;
    } vec_t;

    vec_t tbl[16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int a, input int e);
        total++;
        if (a != e) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, a, e);
        end
    endtask

    task automatic model_press(input logic [3:0] m);
        int d;
        if (m_edit == 0) begin
            m_edit = 1;
        end else begin
            d = m_sel ? m_tens : m_ones;
            if (m[0] && !m[1]) d = (d + 1) % 10;
            else if (m[1] && !m[0]) d = (d + 9) % 10;
            if (m_sel) m_tens = d;
            else       m_ones = d;
            if (m[2]) m_sel = 1 - m_sel;
            if (m[3]) begin
                m_out = m_tens * 10 + m_ones;
                m_edit = 0;
                m_v++;
            end
        end
    endtask

    task automatic act(input logic [3:0] m, input int hold, input int gap);
        key_n = ~m;
        repeat (hold) tick();
        key_n = 4'hF;
        repeat (gap) tick();
        model_press(m);
    endtask

    task automatic chk_model(input string tag);
        chk({tag, " ones"}, int'(edit_ones), m_ones);
        chk({tag, " tens"}, int'(edit_tens), m_tens);
        chk({tag, " sel"}, int'(digit_sel), m_sel);
        chk({tag, " edit"}, int'(editing), m_edit);
        chk({tag, " out"}, int'(out_reg), m_out);
        chk({tag, " valid"}, vcount, m_v);
    endtask

    initial begin
        int tt, to;
        tbl[0]  = '{4'b0001, 0, 0, 0, 1, 0, 0};
        tbl[1]  = '{4'b0001, 1, 0, 0, 1, 0, 0};
        tbl[2]  = '{4'b0001, 2, 0, 0, 1, 0, 0};
        tbl[3]  = '{4'b0001, 3, 0, 0, 1, 0, 0};
        tbl[4]  = '{4'b0100, 3, 0, 1, 1, 0, 0};
        tbl[5]  = '{4'b0010, 3, 9, 1, 1, 0, 0};
        tbl[6]  = '{4'b0011, 3, 9, 1, 1, 0, 0};
        tbl[7]  = '{4'b1000, 3, 9, 1, 0, 93, 1};
        tbl[8]  = '{4'b0100, 3, 9, 1, 1, 93, 1};
        tbl[9]  = '{4'b0100, 3, 9, 0, 1, 93, 1};
        tbl[10] = '{4'b0010, 2, 9, 0, 1, 93, 1};
        tbl[11] = '{4'b0010, 1, 9, 0, 1, 93, 1};
        tbl[12] = '{4'b0010, 0, 9, 0, 1, 93, 1};
        tbl[13] = '{4'b0010, 9, 9, 0, 1, 93, 1};
        tbl[14] = '{4'b0001, 0, 9, 0, 1, 93, 1};
        tbl[15] = '{4'b1001, 1, 9, 0, 0, 91, 2};

        repeat (3) tick();
        rst_n = 1'b1;
        repeat (5) tick();
        chk("reset out", int'(out_reg), 0);
        chk("reset edit", int'(editing), 0);
        chk("reset ones", int'(edit_ones), 0);

        // 3-cycle glitch must not produce an event
        key_n[0] = 1'b0;
        repeat (3) tick();
        key_n[0] = 1'b1;
        repeat (15) tick();
        chk("glitch edit", int'(editing), 0);

        for (int i = 0; i < 16; i++) begin
            act(tbl[i].keys, 8, 10);
            chk($sformatf("vec%0d ones", i), int'(edit_ones), tbl[i].ones);
            chk($sformatf("vec%0d tens", i), int'(edit_tens), tbl[i].tens);
            chk($sformatf("vec%0d sel", i), int'(digit_sel), tbl[i].sel);
            chk($sformatf("vec%0d edit", i), int'(editing), tbl[i].edit);
            chk($sformatf("vec%0d out", i), int'(out_reg), tbl[i].outv);
            chk($sformatf("vec%0d valid", i), vcount, tbl[i].vcnt);
        end

        for (int i = 0; i < 40; i++) begin
            act(4'($urandom_range(1, 15)), $urandom_range(5, 9),
                $urandom_range(8, 12));
            chk_model($sformatf("rnd%0d", i));
        end

        // drive the committed value to 42
        tt = 4;
        to = 2;
        if (m_edit == 0) act(4'b0001, 8, 10);
        if (m_sel == 0) act(4'b0100, 8, 10);
        while (m_tens != tt) act(4'b0001, 8, 10);
        act(4'b0100, 8, 10);
        while (m_ones != to) act(4'b0001, 8, 10);
        act(4'b1000, 8, 10);
        chk("set42 out", int'(out_reg), 42);
        chk_model("set42");

        // timeout abandons edits and reloads digits from out_reg
        act(4'b0001, 8, 10);
        repeat (5) act(4'b0001, 8, 10);
        act(4'b0100, 8, 10);
        chk("pre-to ones", int'(edit_ones), 7);
        chk("pre-to sel", int'(digit_sel), 1);
        repeat (80) tick();
        chk("pre-to edit", int'(editing), 1);
        repeat (25) tick();
        chk("to edit", int'(editing), 0);
        chk("to ones", int'(edit_ones), 2);
        chk("to tens", int'(edit_tens), 4);
        chk("to sel", int'(digit_sel), 0);
        chk("to valid", vcount, m_v);
        chk("to out", int'(out_reg), 42);
        m_edit = 0;
        m_ones = 2;
        m_tens = 4;
        m_sel = 0;

        // reset in EDIT with key 0 held low
        act(4'b0001, 8, 10);
        chk("rst pre edit", int'(editing), 1);
        key_n[0] = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        chk("rst out", int'(out_reg), 0);
        chk("rst valid", int'(out_valid), 0);
        chk("rst ones", int'(edit_ones), 0);
        chk("rst tens", int'(edit_tens), 0);
        chk("rst sel", int'(digit_sel), 0);
        chk("rst edit", int'(editing), 0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (30) tick();
        chk("held edit", int'(editing), 0);
        chk("held valid", vcount, m_v);
        key_n[0] = 1'b1;
        repeat (15) tick();
        chk("rel edit", int'(editing), 0);
        m_ones = 0; m_tens = 0; m_sel = 0; m_edit = 0; m_out = 0;
        act(4'b0001, 8, 10);
        chk("repress edit", int'(editing), 1);
        chk_model("post-rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/key_entry_de10.md
KEY_ENTRY_DE10 -- requirements
Module: key_entry_de10

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 50000, meaning cycles a key must be stable before its debounced level changes (range 2 to 2^20-1).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 250000000, meaning cycles with no press event in EDIT before edits are abandoned (range 2 to 2^32-1).
REQ-003 SHALL have port clk  input  1  system clock; the block uses one clock, and all logic is on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port key_n  input  4  DE10 pushbuttons, active-low, asynchronous: [0] increment, [1] decrement, [2] digit select, [3] commit.
REQ-006 SHALL have port out_reg  output  32  committed value: bits [7:0] binary 0..99, bits [31:8] zero.
REQ-007 SHALL have port out_valid  output  1  one-cycle pulse when out_reg updates.
REQ-008 SHALL have port edit_ones  output  4  BCD ones digit being edited, 0..9.
REQ-009 SHALL have port edit_tens  output  4  BCD tens digit being edited, 0..9.
REQ-010 SHALL have port digit_sel  output  1  selected digit: 0 selects ones, 1 selects tens.
REQ-011 SHALL have port editing  output  1  high while state is EDIT.

Function
REQ-012 SHALL pass each key_n bit through a 2-flop synchronizer before any use.
REQ-013 SHALL keep one debounce counter per key; the counter clears on any cycle where the synchronized level equals the debounced level.
REQ-014 SHALL flip a key's debounced level, and clear its counter, on the cycle its counter reaches DEBOUNCE_CYCLES consecutive differing samples.
REQ-015 SHALL generate a press event, one cycle wide, on each debounced 1->0 transition; release (0->1) SHALL generate no event.
REQ-016 SHALL implement FSM states IDLE, EDIT and COMMIT.
REQ-017 SHALL, in IDLE on any press event, go to EDIT; that press SHALL be consumed without changing digits or digit_sel.
REQ-018 SHALL, in EDIT on increment, set the selected digit to digit+1 with 9 wrapping to 0 and no carry into the other digit.
REQ-019 SHALL, in EDIT on decrement, set the selected digit to digit-1 with 0 wrapping to 9 and no borrow.
REQ-020 SHALL ignore both increment and decrement when they fire in the same cycle.
REQ-021 SHALL, in EDIT on digit select, toggle digit_sel.
REQ-022 SHALL, in EDIT on commit, go to COMMIT; other events in the same cycle SHALL still apply, and the committed value is taken from the digits in COMMIT.
REQ-023 SHALL, in COMMIT for one cycle, load out_reg[7:0] with edit_tens*10+edit_ones, compute the sum without a multiplier (shift-add), and go to IDLE.
REQ-024 SHALL drive out_valid high in the cycle after COMMIT, aligned with the new out_reg value; press events arriving in COMMIT SHALL be dropped.
REQ-025 SHALL keep an inactivity counter in EDIT, cleared on every press event.
REQ-026 SHALL, when the inactivity counter reaches TIMEOUT_CYCLES, reload the digits from out_reg as the BCD of out_reg[7:0], clear digit_sel, go to IDLE, and not pulse out_valid.
REQ-027 SHALL give a timeout that coincides with a press event lower priority than the press; the press applies and the counter clears.
REQ-028 SHALL update edit_ones, edit_tens and digit_sel one cycle after the press event that changes them.
REQ-029 SHALL have a worst-case latency of 2 + DEBOUNCE_CYCLES + 1 cycles from a key_n edge to the press event.

Reset
REQ-030 SHALL, on rst_n low, immediately and asynchronously set:
- synchronizer flops and debounced levels to 1 (released);
- counters to 0;
- state to IDLE;
- out_reg, edit_ones, edit_tens and digit_sel to 0;
- out_valid and editing to 0.
REQ-031 SHALL, after reset, generate no press event for keys held low through reset release until they are released and pressed again.
REQ-032 SHALL, on reset during EDIT or COMMIT, abandon the edit with no out_valid pulse.

Verification (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=100)
REQ-033 SHALL cover: key_n[0] glitching low 3 cycles -> no event and editing stays 0; key_n[0] held low 8 cycles -> exactly one event and editing=1.
REQ-034 SHALL cover: enter EDIT, then 3 increments -> edit_ones=3; select, then 1 decrement -> edit_tens=9; commit -> out_reg=93 and a single out_valid pulse.
REQ-035 SHALL cover: edit_ones=9 and increment -> edit_ones=0 with edit_tens unchanged; edit_tens=0 and decrement -> edit_tens=9.
REQ-036 SHALL cover: increment and decrement pressed together in EDIT -> digits unchanged.
REQ-037 SHALL cover: out_reg=42, enter EDIT and change ones to 7, then idle 100 cycles -> edit_tens=4, edit_ones=2, editing=0, no out_valid.
REQ-038 SHALL cover: rst_n pulsed low in EDIT with key_n[0] held low -> all outputs 0 at once; no event until key_n[0] is released and pressed again.
